// File: rtl/sklansky_divider_8bit_if.sv
// Handshake and data bundle for sklansky_divider_8bit.
//   master : drives enable, start, dividend, divisor; observes the results
//   slave  : the divider itself
//   enable      global enable; low freezes the divider
//   start       division request, accepted only while idle
//   dividend    unsigned dividend
//   divisor     unsigned divisor
//   busy        operation in progress (RUN or DONE)
//   done        one-cycle pulse, results valid
//   quotient    registered quotient
//   remainder   registered remainder
//   div_by_zero last completed operation had divisor == 0
interface sklansky_divider_8bit_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output enable, start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  enable, start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/sklansky_divider_8bit.sv
// Sequential radix-2 restoring divider, one quotient bit per enabled clock.
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      sklansky_divider_8bit_if slave modport (handshake, operands, results)
// A division by a non-zero divisor takes 8 RUN cycles; divisor == 0 goes
// straight to DONE with quotient all-ones and remainder = dividend.
module sklansky_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    sklansky_divider_8bit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [2:0]       count;
    logic [WIDTH:0]   prem;     // partial remainder
    logic [WIDTH-1:0] dvd;      // dividend bits shift out MSB first, quotient bits shift in
    logic [WIDTH-1:0] dsr;      // captured divisor

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             qbit;
    logic [WIDTH:0]   next_rem;

    // One extra guard bit so the sign of the trial subtraction is exact.
    always_comb begin
        shifted  = {prem, dvd[WIDTH-1]};
        trial    = shifted - {2'b00, dsr};
        qbit     = ~trial[WIDTH+1];
        next_rem = qbit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            count           <= '0;
            prem            <= '0;
            dvd             <= '0;
            dsr             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (bus.enable) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dsr      <= bus.divisor;
                        bus.busy <= 1'b1;
                        if (bus.divisor == '0) begin
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            dvd   <= bus.dividend;
                            count <= '0;
                            prem  <= '0;
                        end
                    end
                end
                RUN: begin
                    prem  <= next_rem;
                    dvd   <= {dvd[WIDTH-2:0], qbit};
                    count <= count + 3'd1;
                    if (count == 3'(WIDTH - 1)) begin
                        state           <= DONE;
                        bus.done        <= 1'b1;
                        bus.quotient    <= {dvd[WIDTH-2:0], qbit};
                        bus.remainder   <= next_rem[WIDTH-1:0];
                        bus.div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sklansky_divider_8bit.sv
module tb_sklansky_divider_8bit;
    logic clock;
    logic reset_n;
    int   n_vec;
    int   n_miss;

    sklansky_divider_8bit_if #(.WIDTH(8)) bus ();

    sklansky_divider_8bit #(.WIDTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer division.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic z);
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
            z = 1'b1;
        end else begin
            q = 8'(int'(a) / int'(b));
            r = 8'(int'(a) % int'(b));
            z = 1'b0;
        end
    endtask

    // Launch a/b from IDLE; optionally freeze for dis_len cycles starting at
    // cycle dis_at, and/or pulse a spurious start at cycle poke_at.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input int dis_at, input int dis_len, input int poke_at);
        int         c;
        int         exp_lat;
        logic [7:0] eq;
        logic [7:0] er;
        logic       ez;
        model(a, b, eq, er, ez);
        @(negedge clock);
        bus.enable   = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clock);
        bus.start = 1'b0;
        c = 1;
        while (!bus.done && c < 40) begin
            bus.enable   = !(c >= dis_at && c < dis_at + dis_len);
            bus.start    = (c == poke_at);
            bus.dividend = 8'($urandom);
            bus.divisor  = 8'($urandom);
            @(negedge clock);
            c++;
        end
        bus.enable = 1'b1;
        exp_lat = ((b == 8'd0) ? 1 : 9) + dis_len;
        check("latency", c, exp_lat);
        check("quotient", bus.quotient, eq);
        check("remainder", bus.remainder, er);
        check("div_by_zero", bus.div_by_zero, ez);
        check("busy_in_done", bus.busy, 1'b1);
        if (b != 8'd0)
            check("invariant", int'(bus.quotient) * int'(b) + int'(bus.remainder), a);
        // start during the DONE cycle must be ignored
        bus.start    = 1'b1;
        bus.dividend = 8'($urandom);
        bus.divisor  = 8'($urandom);
        @(negedge clock);
        bus.start = 1'b0;
        check("done_cleared", bus.done, 1'b0);
        check("busy_cleared", bus.busy, 1'b0);
        check("result_persist", bus.quotient, eq);
    endtask

    initial begin
        int         c;
        logic [7:0] a;
        logic [7:0] b;
        n_vec        = 0;
        n_miss       = 0;
        reset_n      = 1'b0;
        bus.enable   = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_quotient", bus.quotient, 8'd0);
        check("rst_remainder", bus.remainder, 8'd0);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        reset_n = 1'b1;

        run_op(8'd200, 8'd7, 0, 0, 0);
        run_op(8'd5, 8'd0, 0, 0, 0);
        run_op(8'd9, 8'd3, 0, 0, 0);
        run_op(8'd255, 8'd1, 0, 0, 0);
        run_op(8'd3, 8'd10, 0, 0, 0);
        run_op(8'd0, 8'd9, 0, 0, 0);
        run_op(8'd100, 8'd9, 0, 0, 3);
        run_op(8'd100, 8'd9, 4, 4, 0);

        // done frozen high while disabled in DONE
        @(negedge clock);
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd4;
        @(negedge clock);
        bus.start = 1'b0;
        c = 1;
        while (!bus.done && c < 40) begin
            @(negedge clock);
            c++;
        end
        check("freeze_latency", c, 9);
        bus.enable = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("freeze_done", bus.done, 1'b1);
            check("freeze_quotient", bus.quotient, 8'd12);
        end
        bus.enable = 1'b1;
        @(negedge clock);
        check("unfreeze_done", bus.done, 1'b0);
        check("unfreeze_busy", bus.busy, 1'b0);

        // reset mid-RUN aborts without a done pulse
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd9;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_quotient", bus.quotient, 8'd0);
        check("abort_remainder", bus.remainder, 8'd0);
        check("abort_dbz", bus.div_by_zero, 1'b0);
        repeat (3) begin
            @(negedge clock);
            check("abort_no_done", bus.done, 1'b0);
        end
        reset_n = 1'b1;
        run_op(8'd100, 8'd9, 0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
            if (b != 8'd0 && $urandom_range(9) == 0)
                run_op(a, b, int'($urandom_range(8, 1)), int'($urandom_range(3, 1)), 0);
            else if ($urandom_range(9) == 0)
                run_op(a, b, 0, 0, int'($urandom_range(8, 1)));
            else
                run_op(a, b, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
